fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_queue.sv | 70 +++++++
 rtl/fetch_unit.sv | 151 +++++++++++++++
 tb/tb_fetch_unit.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: queue entry layout, FSM states
// and the fixed instruction size.
package fetch_pkg;

    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        FULL  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction FIFO between the L1 I-cache and decode; flush wins over
// push/pop, and the head reads as zero whenever the queue is empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  fetch_entry_t               din,
    output fetch_entry_t               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t   mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           do_push, do_pop;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap.
            wr_ptr_d = wr_ptr_q + PW'(do_push);
            rd_ptr_d = rd_ptr_q + PW'(do_pop);
            cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential PC fetch from the L1 I-cache into a small
// queue, with redirects. Define FETCH_PERF_EN to add the STALL_CYCLES counter.
//
// state | meaning
// FETCH | requesting pc; hits are queued, misses hold pc
// FULL  | queue full, no request until decode pops
// DRAIN | redirect arrived mid-miss; wait for refill, drop it, jump to target
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] I_R_ADDR,
    output logic        I_R_ADDR_VALID,
    input  logic [31:0] I_R_DATA,
    input  logic        I_R_DATA_VALID,
    input  logic        REDIRECT_VALID,
    input  logic [63:0] REDIRECT_PC,
    output logic [31:0] INSTR,
    output logic [63:0] INSTR_PC,
    output logic        INSTR_VALID,
`ifdef FETCH_PERF_EN
    output logic [31:0] STALL_CYCLES,
`endif
    input  logic        INSTR_READY
);

    localparam int CW = $clog2(QUEUE_DEPTH + 1);

    fetch_state_t  state_q, state_d;
    logic [63:0]   pc_q, pc_d;
    logic [63:0]   tgt_q, tgt_d;
    logic [63:0]   redirect_tgt;
    logic          q_push, q_pop, q_flush, q_full, q_empty;
    logic [CW-1:0] q_count;
    fetch_entry_t  q_din, q_dout;

    assign redirect_tgt   = REDIRECT_PC & ~64'(INSTR_BYTES - 1);
    assign I_R_ADDR       = pc_q;
    assign I_R_ADDR_VALID = !reset && (state_q != FULL);
    assign INSTR_VALID    = !q_empty;
    assign INSTR          = q_dout.instr;
    assign INSTR_PC       = q_dout.pc;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        q_push  = 1'b0;
        q_pop   = 1'b0;
        q_flush = 1'b0;
        q_din   = '{pc: pc_q, instr: I_R_DATA};
        case (state_q)
            FETCH: begin
                if (REDIRECT_VALID) begin
                    q_flush = 1'b1;
                    if (I_R_DATA_VALID) begin
                        pc_d = redirect_tgt;
                    end else begin
                        tgt_d   = redirect_tgt;
                        state_d = DRAIN;
                    end
                end else begin
                    q_pop = !q_empty && INSTR_READY;
                    if (I_R_DATA_VALID && !q_full) begin
                        q_push = 1'b1;
                        pc_d   = pc_q + 64'(INSTR_BYTES);
                        if (q_count == CW'(QUEUE_DEPTH - 1) && !q_pop) begin
                            state_d = FULL;
                        end
                    end
                end
            end
            FULL: begin
                if (REDIRECT_VALID) begin
                    q_flush = 1'b1;
                    pc_d    = redirect_tgt;
                    state_d = FETCH;
                end else if (INSTR_READY) begin
                    q_pop   = 1'b1;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                // Queue is already flushed here; the refill word is discarded.
                if (REDIRECT_VALID) begin
                    tgt_d = redirect_tgt;
                end else if (I_R_DATA_VALID) begin
                    pc_d    = tgt_q;
                    tgt_d   = '0;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (q_push),
        .pop   (q_pop),
        .flush (q_flush),
        .din   (q_din),
        .dout  (q_dout),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (I_R_ADDR_VALID && !I_R_DATA_VALID && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign STALL_CYCLES = stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic
// compared against a queue-based behavioural model of the fetch rules.
module tb_fetch_unit;

    localparam logic [63:0] RST_PC = 64'h1000;
    localparam int          DEPTH  = 4;

    logic        clk;
    logic        reset;
    logic [63:0] I_R_ADDR;
    logic        I_R_ADDR_VALID;
    logic [31:0] I_R_DATA;
    logic        I_R_DATA_VALID;
    logic        REDIRECT_VALID;
    logic [63:0] REDIRECT_PC;
    logic [31:0] INSTR;
    logic [63:0] INSTR_PC;
    logic        INSTR_VALID;
    logic        INSTR_READY;
`ifdef FETCH_PERF_EN
    logic [31:0] STALL_CYCLES;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: architectural pc, queue of {pc,instr}, pending redirect.
    logic [63:0] m_pc;
    logic [63:0] m_tgt;
    bit          m_drain;
    logic [95:0] m_q[$];
    logic [31:0] m_stall;

    fetch_unit #(
        .RESET_PC    (RST_PC),
        .QUEUE_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .I_R_ADDR       (I_R_ADDR),
        .I_R_ADDR_VALID (I_R_ADDR_VALID),
        .I_R_DATA       (I_R_DATA),
        .I_R_DATA_VALID (I_R_DATA_VALID),
        .REDIRECT_VALID (REDIRECT_VALID),
        .REDIRECT_PC    (REDIRECT_PC),
        .INSTR          (INSTR),
        .INSTR_PC       (INSTR_PC),
        .INSTR_VALID    (INSTR_VALID),
`ifdef FETCH_PERF_EN
        .STALL_CYCLES   (STALL_CYCLES),
`endif
        .INSTR_READY    (INSTR_READY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return 32'hC0DE_0000 ^ a[31:0] ^ {a[15:0], 16'h0};
    endfunction

    function automatic logic [95:0] m_head();
        return (m_q.size() > 0) ? m_q[0] : 96'h0;
    endfunction

    task automatic model_reset();
        m_pc    = RST_PC;
        m_tgt   = '0;
        m_drain = 1'b0;
        m_q.delete();
        m_stall = '0;
    endtask

    task automatic model_update(input bit dv, input logic [31:0] data, input bit rdy,
                                input bit rv, input logic [63:0] rpc);
        bit req;
        bit pop;
        bit push;
        logic [63:0] t;
        req = (m_q.size() < DEPTH);
        t   = {rpc[63:2], 2'b00};
        if (req && !dv && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (m_drain) begin
            if (rv) m_tgt = t;
            else if (dv) begin
                m_pc    = m_tgt;
                m_drain = 1'b0;
            end
        end else if (rv) begin
            m_q.delete();
            if (req && !dv) begin
                m_drain = 1'b1;
                m_tgt   = t;
            end else begin
                m_pc = t;
            end
        end else begin
            pop  = (m_q.size() > 0) && rdy;
            push = req && dv;
            if (pop) void'(m_q.pop_front());
            if (push) begin
                m_q.push_back({m_pc, data});
                m_pc = m_pc + 64'd4;
            end
        end
    endtask

    // Called at a negedge; applies inputs for one cycle and returns at the next negedge.
    task automatic step(input bit dv, input bit rdy, input bit rv, input logic [63:0] rpc);
        I_R_DATA_VALID = dv;
        I_R_DATA       = dv ? word_of(m_pc) : 32'hDEAD_BEEF;
        INSTR_READY    = rdy;
        REDIRECT_VALID = rv;
        REDIRECT_PC    = rpc;
        @(posedge clk);
        model_update(dv, I_R_DATA, rdy, rv, rpc);
        @(negedge clk);
        REDIRECT_VALID = 1'b0;
        I_R_DATA_VALID = 1'b0;
    endtask

    task automatic do_reset();
        I_R_DATA_VALID = 1'b0;
        I_R_DATA       = '0;
        INSTR_READY    = 1'b0;
        REDIRECT_VALID = 1'b0;
        REDIRECT_PC    = '0;
        reset          = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 64'h0);
        reset = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (INSTR_VALID !== 1'b0) begin
            n_fail++; $display("FAIL reset_instr_valid: got %b expected 0", INSTR_VALID);
        end
        @(negedge clk);
        n_checks++;
        if (I_R_ADDR_VALID !== 1'b0) begin
            n_fail++; $display("FAIL reset_addr_valid: got %b expected 0", I_R_ADDR_VALID);
        end
        n_checks++;
        if ({INSTR, INSTR_PC} !== 96'h0) begin
            n_fail++; $display("FAIL reset_instr_zero: got %h %h expected 0 0", INSTR, INSTR_PC);
        end
        n_checks++;
        if (I_R_ADDR !== RST_PC) begin
            n_fail++; $display("FAIL reset_addr: got %h expected %h", I_R_ADDR, RST_PC);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (I_R_ADDR_VALID !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_valid: got %b expected 1", I_R_ADDR_VALID);
        end
`ifdef FETCH_PERF_EN
        n_checks++;
        if (STALL_CYCLES !== 32'd0) begin
            n_fail++; $display("FAIL reset_stall: got %0d expected 0", STALL_CYCLES);
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_pc;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 64'h0);
            exp_pc = RST_PC + 64'(4 * i);
            n_checks++;
            if ({INSTR_VALID, INSTR_PC, INSTR} !== {1'b1, exp_pc, word_of(exp_pc)}) begin
                n_fail++;
                $display("FAIL b2b_instr[%0d]: got v=%b pc=%h i=%h expected v=1 pc=%h i=%h",
                         i, INSTR_VALID, INSTR_PC, INSTR, exp_pc, word_of(exp_pc));
            end
        end
    endtask

    task automatic test_miss();
        do_reset();
        repeat (16) step(1, 1, 0, 64'h0);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if ({I_R_ADDR_VALID, I_R_ADDR} !== {1'b1, 64'h1040}) begin
                n_fail++;
                $display("FAIL miss_hold[%0d]: got v=%b a=%h expected v=1 a=1040",
                         i, I_R_ADDR_VALID, I_R_ADDR);
            end
            step((i == 5), 1, 0, 64'h0);
        end
        n_checks++;
        if (I_R_ADDR !== 64'h1044) begin
            n_fail++; $display("FAIL miss_next_addr: got %h expected 1044", I_R_ADDR);
        end
        n_checks++;
        if (INSTR_PC !== 64'h1040) begin
            n_fail++; $display("FAIL miss_instr_pc: got %h expected 1040", INSTR_PC);
        end
`ifdef FETCH_PERF_EN
        n_checks++;
        if (STALL_CYCLES !== 32'd5) begin
            n_fail++; $display("FAIL miss_stall: got %0d expected 5", STALL_CYCLES);
        end
`endif
    endtask

    task automatic test_full();
        do_reset();
        repeat (4) step(1, 0, 0, 64'h0);
        n_checks++;
        if ({I_R_ADDR_VALID, I_R_ADDR, INSTR_VALID, INSTR_PC} !== {1'b0, RST_PC + 64'd16, 1'b1, RST_PC}) begin
            n_fail++;
            $display("FAIL full_state: got v=%b a=%h iv=%b ipc=%h expected v=0 a=%h iv=1 ipc=%h",
                     I_R_ADDR_VALID, I_R_ADDR, INSTR_VALID, INSTR_PC, RST_PC + 64'd16, RST_PC);
        end
        step(1, 0, 0, 64'h0);
        n_checks++;
        if ({I_R_ADDR_VALID, I_R_ADDR} !== {1'b0, RST_PC + 64'd16}) begin
            n_fail++;
            $display("FAIL full_hold: got v=%b a=%h expected v=0 a=%h", I_R_ADDR_VALID, I_R_ADDR, RST_PC + 64'd16);
        end
        step(1, 1, 0, 64'h0);
        n_checks++;
        if ({I_R_ADDR_VALID, I_R_ADDR, INSTR_PC} !== {1'b1, RST_PC + 64'd16, RST_PC + 64'd4}) begin
            n_fail++;
            $display("FAIL full_pop: got v=%b a=%h ipc=%h expected v=1 a=%h ipc=%h",
                     I_R_ADDR_VALID, I_R_ADDR, INSTR_PC, RST_PC + 64'd16, RST_PC + 64'd4);
        end
        step(1, 1, 0, 64'h0);
        n_checks++;
        if ({I_R_ADDR, INSTR_PC} !== {RST_PC + 64'd20, RST_PC + 64'd8}) begin
            n_fail++;
            $display("FAIL full_pushpop: got a=%h ipc=%h expected a=%h ipc=%h",
                     I_R_ADDR, INSTR_PC, RST_PC + 64'd20, RST_PC + 64'd8);
        end
    endtask

    task automatic test_redirect_hit();
        do_reset();
        repeat (2) step(1, 0, 0, 64'h0);
        step(1, 1, 1, 64'h2003);
        n_checks++;
        if ({INSTR_VALID, I_R_ADDR_VALID, I_R_ADDR} !== {1'b0, 1'b1, 64'h2000}) begin
            n_fail++;
            $display("FAIL redir_hit: got iv=%b v=%b a=%h expected iv=0 v=1 a=2000",
                     INSTR_VALID, I_R_ADDR_VALID, I_R_ADDR);
        end
        step(1, 1, 0, 64'h0);
        n_checks++;
        if ({INSTR_VALID, INSTR_PC, INSTR} !== {1'b1, 64'h2000, word_of(64'h2000)}) begin
            n_fail++;
            $display("FAIL redir_hit_first: got iv=%b ipc=%h i=%h expected iv=1 ipc=2000 i=%h",
                     INSTR_VALID, INSTR_PC, INSTR, word_of(64'h2000));
        end
    endtask

    task automatic test_redirect_miss();
        do_reset();
        repeat (32) step(1, 1, 0, 64'h0);
        step(0, 1, 1, 64'h3000);
        n_checks++;
        if (INSTR_VALID !== 1'b0) begin
            n_fail++; $display("FAIL redir_miss_flush: got %b expected 0", INSTR_VALID);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({I_R_ADDR_VALID, I_R_ADDR} !== {1'b1, 64'h1080}) begin
                n_fail++;
                $display("FAIL redir_miss_hold[%0d]: got v=%b a=%h expected v=1 a=1080",
                         i, I_R_ADDR_VALID, I_R_ADDR);
            end
            step((i == 3), 1, 0, 64'h0);
        end
        n_checks++;
        if ({I_R_ADDR_VALID, I_R_ADDR, INSTR_VALID} !== {1'b1, 64'h3000, 1'b0}) begin
            n_fail++;
            $display("FAIL redir_miss_target: got v=%b a=%h iv=%b expected v=1 a=3000 iv=0",
                     I_R_ADDR_VALID, I_R_ADDR, INSTR_VALID);
        end
        step(1, 1, 0, 64'h0);
        n_checks++;
        if ({INSTR_VALID, INSTR_PC} !== {1'b1, 64'h3000}) begin
            n_fail++;
            $display("FAIL redir_miss_first: got iv=%b ipc=%h expected iv=1 ipc=3000", INSTR_VALID, INSTR_PC);
        end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        step(1, 0, 0, 64'h0);
        step(0, 0, 1, 64'h4000);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if ({INSTR_VALID, I_R_ADDR_VALID, I_R_ADDR} !== {1'b0, 1'b0, RST_PC}) begin
            n_fail++;
            $display("FAIL drain_reset: got iv=%b v=%b a=%h expected iv=0 v=0 a=%h",
                     INSTR_VALID, I_R_ADDR_VALID, I_R_ADDR, RST_PC);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if ({I_R_ADDR_VALID, I_R_ADDR} !== {1'b1, RST_PC}) begin
            n_fail++;
            $display("FAIL drain_reset_release: got v=%b a=%h expected v=1 a=%h", I_R_ADDR_VALID, I_R_ADDR, RST_PC);
        end
        @(negedge clk);
        step(1, 1, 0, 64'h0);
        n_checks++;
        if ({INSTR_VALID, INSTR_PC} !== {1'b1, RST_PC}) begin
            n_fail++;
            $display("FAIL drain_reset_first: got iv=%b ipc=%h expected iv=1 ipc=%h", INSTR_VALID, INSTR_PC, RST_PC);
        end
    endtask

    task automatic test_random();
        logic [161:0] got;
        logic [161:0] exp;
        int           fails_here;
        fails_here = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 24) == 0, {$urandom, $urandom});
            got = {I_R_ADDR_VALID, I_R_ADDR, INSTR_VALID, INSTR_PC, INSTR};
            exp = {m_q.size() < DEPTH, m_pc, m_q.size() > 0, m_head()};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                fails_here++;
                if (fails_here <= 5)
                    $display("FAIL random[%0d]: got %h expected %h", i, got, exp);
            end
`ifdef FETCH_PERF_EN
            n_checks++;
            if (STALL_CYCLES !== m_stall) begin
                n_fail++;
                fails_here++;
                if (fails_here <= 5)
                    $display("FAIL random_stall[%0d]: got %0d expected %0d", i, STALL_CYCLES, m_stall);
            end
`endif
        end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_back_to_back();
        test_miss();
        test_full();
        test_redirect_hit();
        test_redirect_miss();
        test_reset_mid_drain();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
